// File: rtl/axis_frame_demux_pkg.sv
// Shared definitions for the AXI-Stream frame demultiplexer: FSM state
// encodings, drop counter width and the saturating increment helper.
package axis_frame_demux_pkg;

  localparam int DROP_COUNT_WIDTH = 16;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ROUTE = 2'd1;
  localparam state_t ST_DROP  = 2'd2;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [DROP_COUNT_WIDTH-1:0] sat_inc(
    input logic [DROP_COUNT_WIDTH-1:0] value
  );
    return (value == '1) ? value : value + DROP_COUNT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/axis_frame_demux_out_stage.sv
// One-beat output register for a single demux port. A loaded beat is
// presented the next cycle; it is held until the sink takes it.
module axis_frame_demux_out_stage
  import axis_frame_demux_pkg::*;
#(
  parameter int PAYLOAD_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load,
  input  logic [PAYLOAD_WIDTH-1:0] in_payload,
  input  logic                     in_last,
  input  logic                     ready,
  output logic                     valid,
  output logic                     last,
  output logic [PAYLOAD_WIDTH-1:0] payload
);

  // Valid/last control: load wins over drain so back-to-back beats stream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      last  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      last  <= in_last;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

  // Payload capture; not reset, only meaningful while valid is high.
  always_ff @(posedge clk) begin
    if (load) begin
      payload <= in_payload;
    end
  end

endmodule

// File: rtl/axis_frame_demux.sv
// AXI-Stream frame demultiplexer: the tdest of a frame's first beat picks
// one of M_COUNT outputs for the whole frame; out-of-range tdest frames are
// accepted and discarded.
// Handshake: a beat moves on a channel in a cycle where valid and ready are
// both high at the rising edge; valid never waits on ready, and payload is
// held stable while valid is high and ready is low.
// Optional macro AXIS_FRAME_DEMUX_DROP_COUNT_EN builds a saturating count of
// dropped frames on drop_count; without it drop_count is constant zero.
module axis_frame_demux
  import axis_frame_demux_pkg::*;
#(
  parameter int M_COUNT     = 4,
  parameter int DATA_WIDTH  = 8,
  parameter bit KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
  parameter int ID_WIDTH    = 8,
  parameter int DEST_WIDTH  = $clog2(M_COUNT + 1),
  parameter int USER_WIDTH  = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [DATA_WIDTH-1:0]            s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]            s_axis_tkeep,
  input  logic                             s_axis_tvalid,
  output logic                             s_axis_tready,
  input  logic                             s_axis_tlast,
  input  logic [ID_WIDTH-1:0]              s_axis_tid,
  input  logic [DEST_WIDTH-1:0]            s_axis_tdest,
  input  logic [USER_WIDTH-1:0]            s_axis_tuser,
  output logic [M_COUNT*DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [M_COUNT*KEEP_WIDTH-1:0]    m_axis_tkeep,
  output logic [M_COUNT-1:0]               m_axis_tvalid,
  input  logic [M_COUNT-1:0]               m_axis_tready,
  output logic [M_COUNT-1:0]               m_axis_tlast,
  output logic [M_COUNT*ID_WIDTH-1:0]      m_axis_tid,
  output logic [M_COUNT*DEST_WIDTH-1:0]    m_axis_tdest,
  output logic [M_COUNT*USER_WIDTH-1:0]    m_axis_tuser,
  output logic [DROP_COUNT_WIDTH-1:0]      drop_count
);

  localparam int SEL_WIDTH     = $clog2(M_COUNT);
  localparam int PAYLOAD_WIDTH = DATA_WIDTH + KEEP_WIDTH + ID_WIDTH + DEST_WIDTH + USER_WIDTH;
  localparam logic [DEST_WIDTH-1:0] DEST_LIMIT = DEST_WIDTH'(M_COUNT);

  state_t                   state;
  logic [SEL_WIDTH-1:0]     select_reg;
  logic                     dest_ok;
  logic [SEL_WIDTH-1:0]     dec_sel;
  logic [SEL_WIDTH-1:0]     sel;
  logic                     route_path;
  logic                     drop_path;
  logic                     accept;
  logic [M_COUNT-1:0]       load;
  logic [PAYLOAD_WIDTH-1:0] s_payload;
  logic [PAYLOAD_WIDTH-1:0] stage_payload [M_COUNT];

  assign dest_ok   = (s_axis_tdest < DEST_LIMIT);
  assign dec_sel   = s_axis_tdest[SEL_WIDTH-1:0];
  assign s_payload = {s_axis_tdata, s_axis_tkeep, s_axis_tid, s_axis_tdest, s_axis_tuser};

  // Path decode and input ready: the first beat is decoded live, later beats
  // follow the selection frozen in select_reg.
  always_comb begin
    route_path    = 1'b0;
    drop_path     = 1'b0;
    sel           = select_reg;
    s_axis_tready = 1'b0;
    if (state == ST_IDLE) begin
      sel        = dec_sel;
      route_path = s_axis_tvalid && dest_ok;
      drop_path  = s_axis_tvalid && !dest_ok;
    end else if (state == ST_ROUTE) begin
      route_path = 1'b1;
    end else if (state == ST_DROP) begin
      drop_path = 1'b1;
    end
    s_axis_tready = rst_n && (drop_path ||
                    (route_path && (!m_axis_tvalid[sel] || m_axis_tready[sel])));
  end

  assign accept = s_axis_tvalid && s_axis_tready;

  // Per-port load strobe for accepted routed beats.
  always_comb begin
    load = '0;
    for (int i = 0; i < M_COUNT; i++) begin
      load[i] = accept && route_path && (sel == SEL_WIDTH'(i));
    end
  end

  // Frame FSM: selection latched only when the first beat is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      select_reg <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept && !s_axis_tlast) begin
            state      <= dest_ok ? ST_ROUTE : ST_DROP;
            select_reg <= dec_sel;
          end
        end
        ST_ROUTE, ST_DROP: begin
          if (accept && s_axis_tlast) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef AXIS_FRAME_DEMUX_DROP_COUNT_EN
  logic [DROP_COUNT_WIDTH-1:0] drop_count_reg;

  // Count dropped frames on their first accepted beat, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_count_reg <= '0;
    end else if (accept && (state == ST_IDLE) && !dest_ok) begin
      drop_count_reg <= sat_inc(drop_count_reg);
    end
  end

  assign drop_count = drop_count_reg;
`else
  assign drop_count = '0;
`endif

  for (genvar g = 0; g < M_COUNT; g++) begin : g_out
    logic [KEEP_WIDTH-1:0] keep_q;

    axis_frame_demux_out_stage #(
      .PAYLOAD_WIDTH(PAYLOAD_WIDTH)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load[g]),
      .in_payload(s_payload),
      .in_last   (s_axis_tlast),
      .ready     (m_axis_tready[g]),
      .valid     (m_axis_tvalid[g]),
      .last      (m_axis_tlast[g]),
      .payload   (stage_payload[g])
    );

    assign {m_axis_tdata[g*DATA_WIDTH +: DATA_WIDTH],
            keep_q,
            m_axis_tid[g*ID_WIDTH +: ID_WIDTH],
            m_axis_tdest[g*DEST_WIDTH +: DEST_WIDTH],
            m_axis_tuser[g*USER_WIDTH +: USER_WIDTH]} = stage_payload[g];

    assign m_axis_tkeep[g*KEEP_WIDTH +: KEEP_WIDTH] = KEEP_ENABLE ? keep_q : '1;
  end

endmodule

// File: doc/axis_frame_demux.md
Name: axis_frame_demux

Overview:
- Single AXI-Stream input fanned out to M_COUNT outputs; tdest of the first beat selects the output for the whole frame.
- Frames whose tdest has no matching output are consumed and dropped.
- Each output has a one-beat output stage; beats are forwarded with 1-cycle latency at full throughput.
- Used on the egress side of a fabric to split one tagged stream back into per-destination streams.

Parameters:
- M_COUNT, 4: number of outputs (2..16).
- DATA_WIDTH, 8: tdata width.
- KEEP_ENABLE, (DATA_WIDTH>8): propagate tkeep.
- KEEP_WIDTH, DATA_WIDTH/8: tkeep width.
- ID_WIDTH, 8: tid width; tid is always propagated.
- DEST_WIDTH, $clog2(M_COUNT+1): tdest width.
- USER_WIDTH, 1: tuser width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- s_axis_tdata/tkeep/tvalid/tready/tlast/tid/tdest/tuser  in (tready out)  DATA_WIDTH/KEEP_WIDTH/1/1/1/ID_WIDTH/DEST_WIDTH/USER_WIDTH  input stream.
- m_axis_tdata/tkeep/tid/tdest/tuser  out  M_COUNT×field width, packed  output payloads.
- m_axis_tvalid, m_axis_tlast  out  M_COUNT  per-output valid and last.
- m_axis_tready  in  M_COUNT  per-output ready.
- drop_count  out  16  count of dropped frames (see Optional Feature).

Behaviour:
- State machine: IDLE, ROUTE, DROP.
- IDLE, s_axis_tvalid=1, decode tdest:
  - tdest < M_COUNT: target = tdest.
  - tdest >= M_COUNT: drop.
  - Decode is combinational on the first beat; it is latched only when that beat is accepted.
- Transitions:
  - Accepted first beat with tlast=0: go to ROUTE (select_reg = target) or DROP.
  - Accepted first beat with tlast=1: single-beat frame; stay in IDLE.
  - ROUTE/DROP: return to IDLE on an accepted beat with tlast=1.
  - The selection is frozen for the whole frame; tdest on later beats is ignored.
- Handshake:
  - s_axis_tready = drop-path ? 1 : (!m_axis_tvalid[sel] || m_axis_tready[sel]), where sel is the decoded target (IDLE) or select_reg (ROUTE).
  - In IDLE with s_axis_tvalid=0, s_axis_tready=0.
- Output stage (per port): on an accepted routed beat, load the payload and set m_axis_tvalid[sel] the next cycle.
  - Clear m_axis_tvalid[sel] when m_axis_tready[sel] and no new beat is loaded.
  - Back-to-back beats give 1 beat/cycle when m_axis_tready=1.
  - tdest is passed through unmodified.
- Other outputs are unaffected, and their pending beats persist while a frame targets another output.
- Dropped beats never assert any m_axis_tvalid.
- m_axis payload is held stable while m_axis_tvalid=1 and tready=0 (AXIS rule).
- Reset (rst_n low, asynchronous):
  - State to IDLE, all m_axis_tvalid=0, m_axis_tlast=0, drop_count=0, s_axis_tready=0.
  - Payload registers are not reset.
  - Reset mid-frame abandons the frame; the remaining input beats after reset are decoded as a new frame.

Optional Feature:
- AXIS_FRAME_DEMUX_DROP_COUNT_EN.
- Defined: drop_count increments by 1 on each accepted first beat that decodes to drop, and saturates at 16'hFFFF.
- Undefined: drop_count tied to 0, and no counter logic is built.

Decomposition:
- Package axis_frame_demux_pkg: state enum (IDLE/ROUTE/DROP) and DROP_COUNT_WIDTH=16.
- One sub-module, axis_frame_demux_out_stage: per-output one-beat register, instantiated M_COUNT times.

Test Plan:
- Single-beat frame, tdest=2, tdata=8'hA5, all tready=1 -> m_axis_tvalid=4'b0100 one cycle after accept, m_tdata[2]=8'hA5, tlast[2]=1.
- 4-beat frame tdest=1, middle beats with tdest=3 -> all 4 beats on output 1 back-to-back, tlast only on beat 4; output 3 stays idle.
- Frame tdest=5 (M_COUNT=4), 3 beats -> s_axis_tready=1 each cycle, no m_axis_tvalid; drop_count=1 with macro, 0 without.
- Output 0 tready held 0, 2-beat frame to port 0 -> 1st beat held stable, s_axis_tready=0; release tready -> both beats delivered in order.
- Frame to port 0 stalled, next frame to port 3 -> port 3 traffic does not start until the port-0 frame completes (in-order input); port 0 data intact.
- rst_n asserted mid-frame while m_axis_tvalid[1]=1 -> tvalid drops asynchronously; after release, next tdest=0 frame routes to port 0.
